// File: rtl/gaussian_nb_pkg.sv
// gaussian_nb_pkg: mode encodings and default widths/latency for the MAC pipeline
package gaussian_nb_pkg;
  typedef enum logic {MODE_MUL = 1'b0, MODE_MAC = 1'b1} mode_e;
  localparam int DEF_A_W = 16;
  localparam int DEF_B_W = 24;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_OUT_W = 40;
  localparam int DEF_SHIFT = 0;
  localparam int DEF_NUM_STAGE = 4;
endpackage

// File: rtl/gaussian_nb_sat_rnd.sv
// gaussian_nb_sat_rnd: round-half-up arithmetic shift followed by signed clip to OUT_W
module gaussian_nb_sat_rnd #(
  parameter int IN_W = 48,
  parameter int OUT_W = 40,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);
  localparam logic signed [IN_W:0] max_v = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] min_v = ~max_v;
  logic signed [IN_W:0] r;
  // one guard bit keeps the rounding offset from overflowing
  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [IN_W:0] half = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    assign r = ($signed({din[IN_W-1], din}) + half) >>> SHIFT;
  end else begin : g_pass
    assign r = {din[IN_W-1], din};
  end
  assign sat = r > max_v || r < min_v;
  assign dout = r > max_v ? max_v[OUT_W-1:0] : r < min_v ? min_v[OUT_W-1:0] : r[OUT_W-1:0];
endmodule

// File: rtl/gaussian_nb_mac_pipe.sv
// gaussian_nb_mac_pipe: pipelined signed multiply / multiply-accumulate with
// saturating accumulator and rounded, clipped output after NUM_STAGE ce cycles
module gaussian_nb_mac_pipe import gaussian_nb_pkg::*; #(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int NUM_STAGE = DEF_NUM_STAGE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    flush,
  input  logic                    acc_mode,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_valid,
  output logic                    out_sat,
  output logic                    acc_ovf
);
  localparam int P_W = A_W + B_W;
  localparam int LAST = NUM_STAGE - 1;
  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic signed [P_W-1:0] p_q [2:LAST];
  logic [LAST:1] v_q, m_q, f_q, l_q;
  logic signed [ACC_W-1:0] acc, acc_nxt, res_in;
  logic signed [ACC_W:0] sum;
  logic signed [OUT_W-1:0] res;
  logic acc_clip, emit, res_sat;
  // accumulation happens on the edge that registers the final result
  always_comb begin
    sum = (f_q[LAST] ? '0 : {acc[ACC_W-1], acc}) + (ACC_W+1)'(p_q[LAST]);
    acc_clip = sum[ACC_W] != sum[ACC_W-1];
    acc_nxt = acc_clip ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    res_in = m_q[LAST] == MODE_MAC ? acc_nxt : ACC_W'(p_q[LAST]);
    emit = v_q[LAST] && (m_q[LAST] == MODE_MUL || l_q[LAST]);
  end
  gaussian_nb_sat_rnd #(.IN_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_rnd (
    .din(res_in),
    .dout(res),
    .sat(res_sat)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '{default: '0};
      v_q <= '0;
      m_q <= '0;
      f_q <= '0;
      l_q <= '0;
      acc <= '0;
      acc_ovf <= 1'b0;
      dout <= '0;
      out_valid <= 1'b0;
      out_sat <= 1'b0;
    end else if (flush) begin
      v_q <= '0;
      acc <= '0;
      acc_ovf <= 1'b0;
      out_valid <= 1'b0;
      out_sat <= 1'b0;
    end else if (ce) begin
      a_q <= din0;
      b_q <= din1;
      v_q <= {v_q[LAST-1:1], in_valid};
      m_q <= {m_q[LAST-1:1], acc_mode};
      f_q <= {f_q[LAST-1:1], in_first};
      l_q <= {l_q[LAST-1:1], in_last};
      p_q[2] <= a_q * b_q;
      for (int k = 3; k <= LAST; k++) p_q[k] <= p_q[k-1];
      if (v_q[LAST] && m_q[LAST] == MODE_MAC) begin
        acc <= acc_nxt;
        acc_ovf <= acc_ovf | acc_clip;
      end
      out_valid <= emit;
      out_sat <= emit & res_sat;
      if (emit) dout <= res;
    end
endmodule

// File: tb/tb_gaussian_nb_mac_pipe.sv
// tb_gaussian_nb_mac_pipe: three configurations driven in parallel against a beat-level reference model
module tb_gaussian_nb_mac_pipe;
  import gaussian_nb_pkg::*;
  logic clk = 0, reset_n = 0, ce = 0, flush = 0, acc_mode = 0;
  logic in_valid = 0, in_first = 0, in_last = 0;
  logic signed [15:0] din0 = 0;
  logic signed [23:0] din1 = 0;
  logic signed [39:0] d0, d2;
  logic signed [15:0] d1;
  logic [2:0] ov, os, ao;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  gaussian_nb_mac_pipe u0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush), .acc_mode(acc_mode),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(d0), .out_valid(ov[0]), .out_sat(os[0]), .acc_ovf(ao[0])
  );
  gaussian_nb_mac_pipe #(.A_W(16), .B_W(16), .ACC_W(32), .OUT_W(16), .SHIFT(0), .NUM_STAGE(3)) u1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush), .acc_mode(acc_mode),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .din0(din0), .din1(din1[15:0]), .dout(d1), .out_valid(ov[1]), .out_sat(os[1]), .acc_ovf(ao[1])
  );
  gaussian_nb_mac_pipe #(.SHIFT(4), .NUM_STAGE(6)) u2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush), .acc_mode(acc_mode),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(d2), .out_valid(ov[2]), .out_sat(os[2]), .acc_ovf(ao[2])
  );

  localparam int aw [3] = '{16, 16, 16};
  localparam int bw [3] = '{24, 16, 24};
  localparam int accw [3] = '{48, 32, 48};
  localparam int outw [3] = '{40, 16, 40};
  localparam int sh [3] = '{0, 0, 4};
  localparam int ns [3] = '{4, 3, 6};

  typedef struct {longint a; longint b; bit mode; bit first; bit last; int k;} beat_t;
  beat_t log_q[$];
  int rd [3];
  longint acc [3], exp_d [3];
  bit ovf [3], exp_v [3], exp_s [3];
  int cnt = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(longint x, int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint clip(longint x, int w, output bit c);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    c = x > hi || x < -hi - 1;
    return x > hi ? hi : x < -hi - 1 ? -hi - 1 : x;
  endfunction

  task automatic clear_model(bit full);
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      rd[i] = 0; acc[i] = 0; ovf[i] = 0; exp_v[i] = 0; exp_s[i] = 0;
      if (full) exp_d[i] = 0;
    end
  endtask

  // retire the oldest beat of configuration i once its latency in ce edges has elapsed
  task automatic step(int i);
    beat_t bt;
    longint p, v;
    bit c;
    exp_v[i] = 0;
    exp_s[i] = 0;
    if (rd[i] >= log_q.size()) return;
    bt = log_q[rd[i]];
    if (bt.k + ns[i] - 1 != cnt) return;
    rd[i]++;
    p = sx(bt.a, aw[i]) * sx(bt.b, bw[i]);
    if (bt.mode == MODE_MAC) begin
      acc[i] = clip((bt.first ? 0 : acc[i]) + p, accw[i], c);
      ovf[i] |= c;
      v = acc[i];
    end else v = p;
    if (bt.mode == MODE_MUL || bt.last) begin
      if (sh[i] > 0) v = (v + (longint'(1) <<< (sh[i] - 1))) >>> sh[i];
      exp_d[i] = clip(v, outw[i], c);
      exp_v[i] = 1;
      exp_s[i] = c;
    end
  endtask

  always @(posedge clk) begin
    longint gd [3];
    if (!reset_n) clear_model(1);
    else if (flush) clear_model(0);
    else if (ce) begin
      cnt++;
      if (in_valid)
        log_q.push_back('{a: din0, b: din1, mode: acc_mode, first: in_first, last: in_last, k: cnt});
      for (int i = 0; i < 3; i++) step(i);
    end
    #1;
    gd = '{longint'(d0), longint'(d1), longint'(d2)};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d out_valid", i), ov[i], exp_v[i]);
      check($sformatf("u%0d out_sat", i), os[i], exp_s[i]);
      check($sformatf("u%0d acc_ovf", i), ao[i], ovf[i]);
      check($sformatf("u%0d dout", i), gd[i], exp_d[i]);
    end
  end

  task automatic beat(longint a, longint b, bit m, bit f, bit l);
    @(negedge clk);
    ce = 1; flush = 0; in_valid = 1; din0 = 16'(a); din1 = 24'(b);
    acc_mode = m; in_first = f; in_last = l;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1; flush = 0; in_valid = 0;
    end
  endtask

  task automatic stall(int n);
    repeat (n) begin
      @(negedge clk);
      ce = 0; flush = 0; in_valid = 1; din0 = 16'($urandom); din1 = 24'($urandom);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset dout", d0, 0);
    check("reset out_valid", ov, 0);
    check("reset out_sat", os, 0);
    check("reset acc_ovf", ao, 0);
    reset_n = 1;
    idle(2);
    // plain multiply
    beat(-3, 1000, MODE_MUL, 0, 0);
    idle(4);
    check("mul dout", d0, -3000);
    check("mul valid", ov[0], 1);
    check("mul sat", os[0], 0);
    // three-beat accumulation
    beat(2, 5, MODE_MAC, 1, 0);
    beat(3, 7, MODE_MAC, 0, 0);
    beat(-1, 4, MODE_MAC, 0, 1);
    idle(4);
    check("mac dout", d0, 27);
    check("mac valid", ov[0], 1);
    // output clipping on the 16-bit configuration
    beat(32767, 32767, MODE_MUL, 0, 0);
    beat(1, 1, MODE_MUL, 0, 0);
    idle(2);
    check("clip dout", d1, 32767);
    check("clip sat", os[1], 1);
    idle(1);
    check("unclip dout", d1, 1);
    check("unclip sat", os[1], 0);
    // rounding with SHIFT=4
    beat(4, 6, MODE_MUL, 0, 0);
    beat(-4, 6, MODE_MUL, 0, 0);
    idle(5);
    check("rnd pos", d2, 2);
    idle(1);
    check("rnd neg", d2, -1);
    // ce stall stretches latency by two edges
    beat(5, 7, MODE_MUL, 0, 0);
    stall(2);
    beat(6, 7, MODE_MUL, 0, 0);
    idle(3);
    check("stall first", d0, 35);
    idle(1);
    check("stall second", d0, 42);
    // accumulator overflow on the 32-bit accumulator
    beat(32767, 32767, MODE_MAC, 1, 0);
    repeat (3) beat(32767, 32767, MODE_MAC, 0, 0);
    beat(32767, 32767, MODE_MAC, 0, 1);
    idle(3);
    check("ovf sticky", ao[1], 1);
    check("ovf dout", d1, 32767);
    // reset with beats in flight, then flush during an accumulation
    beat(1, 2, MODE_MUL, 0, 0);
    beat(3, 4, MODE_MUL, 0, 0);
    beat(5, 6, MODE_MUL, 0, 0);
    @(negedge clk);
    reset_n = 0; in_valid = 0;
    #1;
    check("midreset dout", d0, 0);
    check("midreset valid", ov, 0);
    check("midreset ovf", ao, 0);
    @(negedge clk);
    reset_n = 1;
    idle(5);
    beat(9, 9, MODE_MAC, 1, 0);
    beat(8, 8, MODE_MAC, 0, 0);
    @(negedge clk);
    flush = 1; in_valid = 1; din0 = 7; din1 = 7; in_last = 1;
    beat(4, 4, MODE_MAC, 1, 1);
    idle(4);
    check("flush dout", d0, 16);
    check("flush ovf", ao[0], 0);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      ce = $urandom_range(0, 4) != 0;
      flush = $urandom_range(0, 59) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      acc_mode = $urandom_range(0, 2) != 0;
      in_first = $urandom_range(0, 5) == 0;
      in_last = $urandom_range(0, 5) == 0;
      din0 = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 20) - 10);
      din1 = $urandom_range(0, 1) ? 24'($urandom) : 24'($urandom_range(0, 20) - 10);
    end
    idle(8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
